// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store/legality helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned LSU_TO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Natural alignment by size; size code 11 and unsigned stores are rejected.
  function automatic logic lsu_legal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok & ~(is_store & f3[2]);
  endfunction

  function automatic logic [3:0] lsu_store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] lsu_store_data(input logic [2:0] f3,
                                                     input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// req/gnt/rvalid data-memory bus between the load/store unit and its responder.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;

  always_comb begin
    w_shift = i_rdata >> {i_addr, 3'b000};
    case (i_funct3)
      F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   o_data = {24'b0, w_shift[7:0]};
      F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   o_data = {16'b0, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues aligned, strobed bus requests, stalls until the
// access completes, and reports misaligned or timed-out accesses with the done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  ALU_result,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             stall,
  output logic             done,
  output logic [XLEN-1:0]  load_data,
  output logic             misaligned,
  output logic             bus_err,
  load_store_unit_if.master dmem
);

  localparam logic [LSU_TO_W-1:0] TO_LAST = LSU_TO_W'(TIMEOUT - 1);

  lsu_state_t            r_state;
  logic [LSU_TO_W-1:0]   r_cnt;
  logic                  r_is_load;
  logic [2:0]            r_f3;
  logic [1:0]            r_addr_lo;
  logic                  r_done;
  logic                  r_misaligned;
  logic                  r_bus_err;
  logic [XLEN-1:0]       r_load_data;
  logic                  r_req;
  logic                  r_we;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [3:0]            r_wstrb;

  logic                  w_op;
  logic                  w_legal;
  logic [XLEN-1:0]       w_load_val;

  assign w_op    = mem_read | mem_write;
  assign w_legal = lsu_legal(~mem_read, funct3, ALU_result[1:0]);
  assign stall   = ((r_state == IDLE) & w_op) | (r_state == REQ) | (r_state == WAIT);

  assign done            = r_done;
  assign misaligned      = r_misaligned;
  assign bus_err         = r_bus_err;
  assign load_data       = r_load_data;
  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_wstrb = r_wstrb;

  lsu_load_align u_load_align (
    .i_rdata  (dmem.dmem_rdata),
    .i_addr   (r_addr_lo),
    .i_funct3 (r_f3),
    .o_data   (w_load_val)
  );

  // Completion takes priority on the last allowed cycle; a grant on that cycle
  // leaves no budget for the read response, so the following WAIT cycle aborts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_load    <= 1'b0;
      r_f3         <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_load_data  <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= 4'b0000;
    end else begin
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_op) begin
            r_is_load <= mem_read;
            r_f3      <= funct3;
            r_addr_lo <= ALU_result[1:0];
            if (w_legal) begin
              r_state <= REQ;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= ~mem_read;
              r_addr  <= {ALU_result[XLEN-1:2], 2'b00};
              r_wdata <= mem_read ? '0 : lsu_store_data(funct3, rs2_data);
              r_wstrb <= mem_read ? 4'b0000 : lsu_store_strb(funct3, ALU_result[1:0]);
            end else begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
              r_load_data  <= '0;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + LSU_TO_W'(1);
          if (dmem.dmem_gnt) begin
            r_req <= 1'b0;
            if (r_is_load) begin
              r_state <= WAIT;
            end else begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_load_data <= '0;
            end
          end else if (r_cnt >= TO_LAST) begin
            r_req       <= 1'b0;
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + LSU_TO_W'(1);
          if (dmem.dmem_rvalid && (r_cnt <= TO_LAST)) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_load_data <= w_load_val;
          end else if (r_cnt >= TO_LAST) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver/responder issues ops and pushes
// expected results from a behavioural model; a monitor checks bus fields and completions.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TB_TO = 5;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] ALU_result;
  logic [31:0] rs2_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  load_store_unit_if dmem_if ();

  load_store_unit #(.TIMEOUT(TB_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .ALU_result (ALU_result),
    .rs2_data   (rs2_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .dmem       (dmem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          issue;
    int          lat;
    int          req_cycles;
    logic        mis;
    logic        berr;
    logic [31:0] ld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: outcome of one access from size/alignment rules and the
  // responder's grant delay g and response delay r, against a REQ+WAIT budget.
  function automatic exp_t model(input logic is_load, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input int g, input int r,
                                 input int issue);
    exp_t e;
    int nbytes, off, last;
    logic legal;
    longint unsigned v, mask;
    nbytes = 1 << f3[1:0];
    off    = int'(addr[1:0]);
    legal  = (f3[1:0] != 2'b11) && !(!is_load && f3[2]) && (off % nbytes == 0);
    e.issue = issue;
    e.mis   = !legal;
    e.berr  = 1'b0;
    e.ld    = 32'h0;
    e.we    = !is_load;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wstrb = 4'b0000;
    e.wdata = 32'h0;
    if (!is_load && legal) begin
      e.wstrb = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % nbytes) +: 8];
    end
    if (!legal) begin
      e.lat = 1; e.req_cycles = 0;
    end else if (g >= TB_TO) begin
      e.berr = 1'b1; e.lat = TB_TO + 1; e.req_cycles = TB_TO;
    end else if (!is_load) begin
      e.lat = g + 2; e.req_cycles = g + 1;
    end else begin
      e.req_cycles = g + 1;
      if (g + 1 + r <= TB_TO - 1) begin
        e.lat = g + 3 + r;
        mask  = (64'd1 << (8 * nbytes)) - 64'd1;
        v     = 64'(rdata >> (8 * off)) & mask;
        if (!f3[2] && (((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
        e.ld  = v[31:0];
      end else begin
        e.berr = 1'b1;
        last   = (TB_TO - 1 > g + 1) ? TB_TO - 1 : g + 1;
        e.lat  = 2 + last;
      end
    end
    return e;
  endfunction

  // Driver plus responder: grants after g requesting cycles, answers r cycles into WAIT.
  task automatic run_op(input logic is_load, input logic both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int g, input int r);
    int nreq = 0;
    int wcnt = -1;
    bit fin = 0;
    @(negedge clk);
    mem_read   = is_load;
    mem_write  = !is_load || both;
    funct3     = f3;
    ALU_result = addr;
    rs2_data   = rs2;
    dmem_if.dmem_rdata = rdata;
    exp_q.push_back(model(is_load, f3, addr, rs2, rdata, g, r, cyc));
    #1 check("stall_issue", 32'(stall), 32'd1);
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      dmem_if.dmem_gnt    = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      if (done) begin
        fin = 1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end else begin
        check("stall_busy", 32'(stall), 32'd1);
        if (wcnt >= 0) begin
          if (wcnt == r) dmem_if.dmem_rvalid = 1'b1;
          wcnt++;
        end
        if (dmem_if.dmem_req) begin
          if (nreq == g) begin
            dmem_if.dmem_gnt = 1'b1;
            if (is_load) wcnt = 0;
          end
          nreq++;
        end
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL op_timeout: no done within 400 cycles, addr 0x%0h", addr);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      exp_q.delete();
    end
  endtask

  // Monitor: bus fields while requesting, full result check on every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_cnt = 0;
      end else begin
        if (dmem_if.dmem_req) begin
          req_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_idle: dmem_req=1 with no op outstanding");
          end else begin
            check("req_addr",  dmem_if.dmem_addr, exp_q[0].addr);
            check("req_we",    32'(dmem_if.dmem_we), 32'(exp_q[0].we));
            check("req_wstrb", 32'(dmem_if.dmem_wstrb), 32'(exp_q[0].wstrb));
            if (exp_q[0].we) check("req_wdata", dmem_if.dmem_wdata, exp_q[0].wdata);
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done: done=1 with no op outstanding");
          end else begin
            mon_e = exp_q.pop_front();
            check("load_data",  load_data, mon_e.ld);
            check("misaligned", 32'(misaligned), 32'(mon_e.mis));
            check("bus_err",    32'(bus_err), 32'(mon_e.berr));
            check("latency",    32'(cyc - mon_e.issue), 32'(mon_e.lat));
            check("req_cycles", 32'(req_cnt), 32'(mon_e.req_cycles));
            check("stall_done", 32'(stall), 32'd0);
          end
          req_cnt = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_mis"},   32'(misaligned), 32'd0);
    check({tag, "_berr"},  32'(bus_err), 32'd0);
    check({tag, "_req"},   32'(dmem_if.dmem_req), 32'd0);
    check({tag, "_we"},    32'(dmem_if.dmem_we), 32'd0);
    check({tag, "_addr"},  dmem_if.dmem_addr, 32'd0);
    check({tag, "_wdata"}, dmem_if.dmem_wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(dmem_if.dmem_wstrb), 32'd0);
    check({tag, "_ld"},    load_data, 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // Reset asserted while the load waits for its response; the response arrives late.
  task automatic reset_mid_wait();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; ALU_result = 32'h40;
    dmem_if.dmem_rdata = 32'h5555_AAAA;
    exp_q.push_back(model(1'b1, F3_W, 32'h40, 32'h0, 32'h5555_AAAA, 0, 100, cyc));
    @(negedge clk);
    check("rst_test_req", 32'(dmem_if.dmem_req), 32'd1);
    dmem_if.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_if.dmem_gnt = 1'b0;
    check("rst_test_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0; mem_read = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dmem_if.dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_if.dmem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_ld", load_data, 32'd0);
  endtask

  task automatic stray_response();
    repeat (2) begin
      @(negedge clk);
      dmem_if.dmem_gnt = 1'b1; dmem_if.dmem_rvalid = 1'b1;
    end
    @(negedge clk);
    dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_ld", load_data, 32'd0);
    check("stray_done", 32'(done), 32'd0);
  endtask

  initial begin
    logic        il, bth;
    logic [2:0]  f3;
    logic [31:0] a, d, rd;
    int          g, r;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    ALU_result = 32'h0; rs2_data = 32'h0;
    dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, F3_B,  32'h0000_0013, 32'h1234_56AB, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, F3_B,  32'h0000_0021, 32'h0, 32'h0000_8000, 0, 0);
    run_op(1'b1, 1'b0, F3_BU, 32'h0000_0021, 32'h0, 32'h0000_8000, 0, 0);
    run_op(1'b1, 1'b0, F3_W,  32'h0000_000A, 32'h0, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, F3_W,  32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 0);
    run_op(1'b1, 1'b0, F3_H,  32'h0000_0006, 32'h0, 32'h8001_0000, 0, 0);
    reset_mid_wait();
    run_op(1'b0, 1'b0, F3_W,  32'h0000_0044, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, F3_W,  32'h0000_0080, 32'h0, 32'h1357_9BDF, 1, 1);
    run_op(1'b1, 1'b0, F3_W,  32'h0000_0084, 32'h0, 32'h0, 10, 0);
    stray_response();
    run_op(1'b1, 1'b1, F3_HU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h9876_5432, 0, 2);
    run_op(1'b0, 1'b0, 3'b100, 32'h0000_0010, 32'h1111_2222, 32'h0, 0, 0);
    run_op(1'b0, 1'b0, F3_H,  32'h0000_0012, 32'hABCD_1234, 32'h0, 4, 0);

    for (int n = 0; n < 300; n++) begin
      il  = 1'($urandom_range(0, 1));
      bth = il & ($urandom_range(0, 7) == 0);
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      d   = $urandom;
      rd  = $urandom;
      g   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      r   = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(il, bth, f3, a, d, rd, g, r);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
